command_issuer: RTL and testbench

COMMAND_ISSUER -- requirements
Module: command_issuer

---
 rtl/types_def.sv | 44 ++++
 rtl/command_issuer_if.sv | 23 ++
 rtl/data_slot_tracker.sv | 115 +++++++++++
 rtl/command_issuer.sv | 194 +++++++++++++++++++
 tb/tb_command_issuer.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/types_def.sv
// Shared types for the command issuer slice.
//   command_t    : scheduled command from the timing controller
//   r_type_t     : direction of a tracked column burst
//   slot_state_t : per-slot data tracker state
//   pins_t       : DDR4 control pin group {cs_n, act_n, ras_n, cas_n, we_n}
package types_def;

  typedef enum logic [2:0] {
    CMD_NONE      = 3'd0,
    CMD_ACTIVATE  = 3'd1,
    CMD_PRECHARGE = 3'd2,
    CMD_READ      = 3'd3,
    CMD_WRITE     = 3'd4
  } command_t;

  typedef enum logic {
    R_READ  = 1'b0,
    R_WRITE = 1'b1
  } r_type_t;

  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,
    SLOT_WAIT  = 2'd1,
    SLOT_BURST = 2'd2
  } slot_state_t;

  typedef struct packed {
    logic cs_n;
    logic act_n;
    logic ras_n;
    logic cas_n;
    logic we_n;
  } pins_t;

  localparam pins_t PINS_NONE      = '{cs_n: 1'b1, act_n: 1'b1, ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b1};
  localparam pins_t PINS_READ      = '{cs_n: 1'b0, act_n: 1'b1, ras_n: 1'b1, cas_n: 1'b0, we_n: 1'b1};
  localparam pins_t PINS_WRITE     = '{cs_n: 1'b0, act_n: 1'b1, ras_n: 1'b1, cas_n: 1'b0, we_n: 1'b0};
  localparam pins_t PINS_PRECHARGE = '{cs_n: 1'b0, act_n: 1'b1, ras_n: 1'b0, cas_n: 1'b1, we_n: 1'b0};

  function automatic logic is_column(command_t c);
    return (c == CMD_READ) || (c == CMD_WRITE);
  endfunction

endpackage

// File: rtl/command_issuer_if.sv
// DDR4 command/address pin bundle.
//   master : driven by command_issuer
//   slave  : observed by the DRAM model / board side
interface command_issuer_if;
  logic        dram_cs_n;
  logic        dram_act_n;
  logic        dram_ras_n;
  logic        dram_cas_n;
  logic        dram_we_n;
  logic [1:0]  dram_bg_o;
  logic [1:0]  dram_ba_o;
  logic [16:0] dram_addr_o;

  modport master (
    output dram_cs_n, dram_act_n, dram_ras_n, dram_cas_n, dram_we_n,
    output dram_bg_o, dram_ba_o, dram_addr_o
  );

  modport slave (
    input dram_cs_n, dram_act_n, dram_ras_n, dram_cas_n, dram_we_n,
    input dram_bg_o, dram_ba_o, dram_addr_o
  );
endinterface

// File: rtl/data_slot_tracker.sv
// One data-tracker slot: IDLE -> WAIT (latency countdown) -> BURST -> IDLE.
//   load/load_*  : (re)load the slot; a countdown of 0 enters BURST directly
//   clear        : drop the slot to IDLE (used when its contents move elsewhere)
//   can_burst    : 1 lets the slot enter BURST; 0 makes it hold at countdown 0
//   state/slot_* : current contents; cnt = cycles until first beat
//   finishing    : slot is on its last beat this cycle
//   expiring     : countdown reaches 0 at the next edge
module data_slot_tracker
  import types_def::*;
#(
  parameter int IW         = 2,
  parameter int BW         = 3,
  parameter int CW         = 3,
  parameter int burst_time = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  r_type_t       load_type,
  input  logic [IW-1:0] load_index,
  input  logic [CW-1:0] load_cnt,
  input  logic          clear,
  input  logic          can_burst,
  output slot_state_t   state,
  output r_type_t       slot_type,
  output logic [IW-1:0] slot_index,
  output logic [CW-1:0] cnt,
  output logic [BW-1:0] beat,
  output logic          finishing,
  output logic          expiring
);

  localparam logic [BW-1:0] LAST_BEAT = BW'(burst_time - 1);

  slot_state_t   state_reg, state_next;
  r_type_t       type_reg, type_next;
  logic [IW-1:0] index_reg, index_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [BW-1:0] beat_reg, beat_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= SLOT_IDLE;
      type_reg  <= R_READ;
      index_reg <= '0;
      cnt_reg   <= '0;
      beat_reg  <= '0;
    end else begin
      state_reg <= state_next;
      type_reg  <= type_next;
      index_reg <= index_next;
      cnt_reg   <= cnt_next;
      beat_reg  <= beat_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    type_next  = type_reg;
    index_next = index_reg;
    cnt_next   = cnt_reg;
    beat_next  = beat_reg;
    if (load) begin
      type_next  = load_type;
      index_next = load_index;
      beat_next  = '0;
      if (load_cnt == '0) begin
        state_next = SLOT_BURST;
        cnt_next   = '0;
      end else begin
        state_next = SLOT_WAIT;
        cnt_next   = load_cnt;
      end
    end else if (clear) begin
      state_next = SLOT_IDLE;
      cnt_next   = '0;
      beat_next  = '0;
    end else begin
      case (state_reg)
        SLOT_WAIT: begin
          if (cnt_reg <= CW'(1)) begin
            // A slot that may not burst parks at 0 until it is promoted.
            cnt_next = '0;
            if (can_burst) begin
              state_next = SLOT_BURST;
              beat_next  = '0;
            end
          end else begin
            cnt_next = cnt_reg - CW'(1);
          end
        end
        SLOT_BURST: begin
          if (beat_reg == LAST_BEAT) begin
            state_next = SLOT_IDLE;
            beat_next  = '0;
          end else begin
            beat_next = beat_reg + BW'(1);
          end
        end
        default: begin
          state_next = SLOT_IDLE;
        end
      endcase
    end
  end

  assign state      = state_reg;
  assign slot_type  = type_reg;
  assign slot_index = index_reg;
  assign cnt        = cnt_reg;
  assign beat       = beat_reg;
  assign finishing  = (state_reg == SLOT_BURST) && (beat_reg == LAST_BEAT);
  assign expiring   = (state_reg == SLOT_WAIT) && (cnt_reg == CW'(1));

endmodule

// File: rtl/command_issuer.sv
// Drives DDR4 command/address pins one cycle after a scheduled command is
// sampled, and tracks column commands to produce data-path beat strobes.
//   clk, rst_n            : clock, synchronous active-low reset
//   cmd_i, cmd_index_i    : scheduled command and the burst slot owning it
//   in_burst_address_*    : per-slot bank group / bank / row / column
//   dram                  : DDR4 pin bundle (master side)
//   rd/wr_data_en_o       : beat strobes; data_index_o / beat_o qualify them
//   burst_done_o          : pulse on the last beat, done_index_o = its slot
//   protocol_err_o        : sticky, cleared only by reset
module command_issuer
  import types_def::*;
#(
  parameter int no_of_bursts = 4,
  parameter int rd_to_data   = 6,
  parameter int wr_to_data   = 4,
  parameter int burst_time   = 8,
  localparam int IW = $clog2(no_of_bursts),
  localparam int BW = $clog2(burst_time)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  command_t      cmd_i,
  input  logic [IW-1:0] cmd_index_i,
  input  logic [1:0]    in_burst_address_bg   [no_of_bursts],
  input  logic [1:0]    in_burst_address_bank [no_of_bursts],
  input  logic [15:0]   in_burst_address_row  [no_of_bursts],
  input  logic [9:0]    in_burst_address_col  [no_of_bursts],
  command_issuer_if.master dram,
  output logic          rd_data_en_o,
  output logic          wr_data_en_o,
  output logic [IW-1:0] data_index_o,
  output logic [BW-1:0] beat_o,
  output logic          burst_done_o,
  output logic [IW-1:0] done_index_o,
  output logic          protocol_err_o
);

  localparam int MAX_LAT = (rd_to_data > wr_to_data) ? rd_to_data : wr_to_data;
  localparam int CW      = $clog2(MAX_LAT + 1);

  // ---------------- pin encoding ----------------
  pins_t       pins_reg, pins_next;
  logic [1:0]  bg_reg, bg_next, ba_reg, ba_next;
  logic [16:0] addr_reg, addr_next;
  logic [15:0] sel_row;
  logic [9:0]  sel_col;

  assign sel_row = in_burst_address_row[cmd_index_i];
  assign sel_col = in_burst_address_col[cmd_index_i];

  always_comb begin
    pins_next = PINS_NONE;
    bg_next   = '0;
    ba_next   = '0;
    addr_next = '0;
    case (cmd_i)
      CMD_ACTIVATE: begin
        // With ACT_n low, RAS_n/CAS_n/WE_n carry address bits A16..A14.
        pins_next = '{cs_n: 1'b0, act_n: 1'b0, ras_n: 1'b0, cas_n: sel_row[15], we_n: sel_row[14]};
        addr_next = {1'b0, sel_row};
      end
      CMD_PRECHARGE: pins_next = PINS_PRECHARGE;
      CMD_READ: begin
        pins_next = PINS_READ;
        addr_next = {7'd0, sel_col};
      end
      CMD_WRITE: begin
        pins_next = PINS_WRITE;
        addr_next = {7'd0, sel_col};
      end
      default: pins_next = PINS_NONE;
    endcase
    if (cmd_i != CMD_NONE) begin
      bg_next = in_burst_address_bg[cmd_index_i];
      ba_next = in_burst_address_bank[cmd_index_i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pins_reg <= PINS_NONE;
      bg_reg   <= '0;
      ba_reg   <= '0;
      addr_reg <= '0;
    end else begin
      pins_reg <= pins_next;
      bg_reg   <= bg_next;
      ba_reg   <= ba_next;
      addr_reg <= addr_next;
    end
  end

  assign dram.dram_cs_n   = pins_reg.cs_n;
  assign dram.dram_act_n  = pins_reg.act_n;
  assign dram.dram_ras_n  = pins_reg.ras_n;
  assign dram.dram_cas_n  = pins_reg.cas_n;
  assign dram.dram_we_n   = pins_reg.we_n;
  assign dram.dram_bg_o   = bg_reg;
  assign dram.dram_ba_o   = ba_reg;
  assign dram.dram_addr_o = addr_reg;

  // ---------------- data tracker ----------------
  slot_state_t   act_state, pend_state;
  r_type_t       act_type, pend_type, new_type, act_load_type;
  logic [IW-1:0] act_index, pend_index, act_load_index;
  logic [CW-1:0] act_cnt, pend_cnt, new_cnt, promo_cnt, act_load_cnt;
  logic [BW-1:0] act_beat, pend_beat;
  logic          act_finishing, pend_finishing, act_expiring, pend_expiring;
  logic          col_cmd, act_busy, pend_busy, promote;
  logic          act_load, pend_load, pend_clear, err_set, err_reg;
  logic          unused_slot_bits;

  assign col_cmd  = is_column(cmd_i);
  assign new_type = (cmd_i == CMD_WRITE) ? R_WRITE : R_READ;
  assign new_cnt  = (cmd_i == CMD_WRITE) ? CW'(wr_to_data) : CW'(rd_to_data);
  assign act_busy  = (act_state != SLOT_IDLE);
  assign pend_busy = (pend_state != SLOT_IDLE);

  // PENDING moves into ACTIVE whenever ACTIVE is about to be free; its
  // countdown is advanced by the edge it crosses so the first beat keeps
  // its original cycle (0 means "start bursting now").
  assign promote   = pend_busy && (!act_busy || act_finishing);
  assign promo_cnt = (pend_cnt > CW'(1)) ? (pend_cnt - CW'(1)) : '0;

  // A new column command goes to ACTIVE only if both slots are empty;
  // otherwise it queues in PENDING, which may be vacated by a promotion.
  assign act_load   = promote || (col_cmd && !act_busy && !pend_busy);
  assign pend_load  = col_cmd && (promote || (act_busy && !pend_busy));
  assign pend_clear = promote && !pend_load;

  assign act_load_type  = promote ? pend_type  : new_type;
  assign act_load_index = promote ? pend_index : cmd_index_i;
  assign act_load_cnt   = promote ? promo_cnt  : new_cnt;

  // Errors: a command with nowhere to go, or PENDING due while ACTIVE
  // still owns the data bus.
  assign err_set = (col_cmd && act_busy && pend_busy && !promote) ||
                   (pend_expiring && !promote);

  data_slot_tracker #(.IW(IW), .BW(BW), .CW(CW), .burst_time(burst_time)) u_active (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (act_load),
    .load_type  (act_load_type),
    .load_index (act_load_index),
    .load_cnt   (act_load_cnt),
    .clear      (1'b0),
    .can_burst  (1'b1),
    .state      (act_state),
    .slot_type  (act_type),
    .slot_index (act_index),
    .cnt        (act_cnt),
    .beat       (act_beat),
    .finishing  (act_finishing),
    .expiring   (act_expiring)
  );

  data_slot_tracker #(.IW(IW), .BW(BW), .CW(CW), .burst_time(burst_time)) u_pending (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (pend_load),
    .load_type  (new_type),
    .load_index (cmd_index_i),
    .load_cnt   (new_cnt),
    .clear      (pend_clear),
    .can_burst  (1'b0),
    .state      (pend_state),
    .slot_type  (pend_type),
    .slot_index (pend_index),
    .cnt        (pend_cnt),
    .beat       (pend_beat),
    .finishing  (pend_finishing),
    .expiring   (pend_expiring)
  );

  assign unused_slot_bits = ^{act_cnt, act_expiring, pend_beat, pend_finishing};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else if (err_set) begin
      err_reg <= 1'b1;
    end
  end

  assign rd_data_en_o   = (act_state == SLOT_BURST) && (act_type == R_READ);
  assign wr_data_en_o   = (act_state == SLOT_BURST) && (act_type == R_WRITE);
  assign data_index_o   = (act_state == SLOT_BURST) ? act_index : '0;
  assign beat_o         = (act_state == SLOT_BURST) ? act_beat : '0;
  assign burst_done_o   = act_finishing;
  assign done_index_o   = act_finishing ? act_index : '0;
  assign protocol_err_o = err_reg;

endmodule

// File: tb/tb_command_issuer.sv
// Directed bench for command_issuer. Cycle c of a test is the cycle after
// the c-th clock edge following reset release; a command driven in cycle
// c-1 appears on the pins in cycle c.
module tb_command_issuer;
  import types_def::*;

  localparam int NB = 4;
  localparam int IW = 2;
  localparam int BW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  command_t      cmd_i = CMD_NONE;
  logic [IW-1:0] cmd_index_i = '0;
  logic [1:0]    bg_tbl  [NB];
  logic [1:0]    ba_tbl  [NB];
  logic [15:0]   row_tbl [NB];
  logic [9:0]    col_tbl [NB];
  logic          rd_en, wr_en, done, err;
  logic [IW-1:0] data_index, done_index;
  logic [BW-1:0] beat;

  int total = 0;
  int bad   = 0;

  command_issuer_if dram_bus();

  command_issuer #(
    .no_of_bursts (NB),
    .rd_to_data   (6),
    .wr_to_data   (4),
    .burst_time   (8)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .cmd_i                 (cmd_i),
    .cmd_index_i           (cmd_index_i),
    .in_burst_address_bg   (bg_tbl),
    .in_burst_address_bank (ba_tbl),
    .in_burst_address_row  (row_tbl),
    .in_burst_address_col  (col_tbl),
    .dram                  (dram_bus),
    .rd_data_en_o          (rd_en),
    .wr_data_en_o          (wr_en),
    .data_index_o          (data_index),
    .beat_o                (beat),
    .burst_done_o          (done),
    .done_index_o          (done_index),
    .protocol_err_o        (err)
  );

  always #5 clk = ~clk;

  // {cs_n, act_n, ras_n, cas_n, we_n}
  wire [4:0] pins_obs = {dram_bus.dram_cs_n, dram_bus.dram_act_n, dram_bus.dram_ras_n,
                         dram_bus.dram_cas_n, dram_bus.dram_we_n};
  wire [20:0] loc_obs = {dram_bus.dram_bg_o, dram_bus.dram_ba_o, dram_bus.dram_addr_o};
  // {rd, wr, beat, data_index, done, done_index}
  wire [9:0]  dp_obs  = {rd_en, wr_en, beat, data_index, done, done_index};

  function automatic logic [9:0] dp_vec(logic r, logic w, int b, int idx, logic dn, int didx);
    return {r, w, 3'(b), 2'(idx), dn, 2'(didx)};
  endfunction

  function automatic logic [20:0] loc_vec(int g, int k, int a);
    return {2'(g), 2'(k), 17'(a)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cmd_i = CMD_NONE;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (pins_obs !== 5'b11111) begin bad++; $display("FAIL reset_pins got=%b want=11111", pins_obs); end
    total++; if (loc_obs !== 21'd0) begin bad++; $display("FAIL reset_loc got=%h want=0", loc_obs); end
    total++; if (dp_obs !== 10'd0) begin bad++; $display("FAIL reset_datapath got=%h want=0", dp_obs); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
    // Reset wins over a command sampled at the same edge.
    cmd_i = CMD_ACTIVATE; cmd_index_i = 2'd2; rst_n = 1'b0;
    step();
    total++; if (pins_obs !== 5'b11111) begin bad++; $display("FAIL reset_over_cmd got=%b want=11111", pins_obs); end
    total++; if (loc_obs !== 21'd0) begin bad++; $display("FAIL reset_over_cmd_loc got=%h want=0", loc_obs); end
    cmd_i = CMD_NONE; rst_n = 1'b1;
    $display("test_reset: checks=%0d", total);
  endtask

  task automatic test_activate_precharge();
    do_reset();
    for (int c = 0; c <= 25; c++) begin
      cmd_i = CMD_NONE;
      if (c == 9)  begin cmd_i = CMD_ACTIVATE;  cmd_index_i = 2'd2; end
      if (c == 12) begin cmd_i = CMD_PRECHARGE; cmd_index_i = 2'd3; end
      if (c == 14) begin cmd_i = CMD_ACTIVATE;  cmd_index_i = 2'd3; end
      if (c == 10) begin
        total++; if (pins_obs[4:3] !== 2'b00) begin bad++; $display("FAIL act_pins got=%b want=00", pins_obs[4:3]); end
        total++; if (loc_obs !== loc_vec(1, 3, 'h01234)) begin bad++; $display("FAIL act_loc got=%h want=%h", loc_obs, loc_vec(1, 3, 'h01234)); end
      end
      if (c == 11) begin
        total++; if (pins_obs !== 5'b11111) begin bad++; $display("FAIL act_next_none got=%b want=11111", pins_obs); end
        total++; if (loc_obs !== 21'd0) begin bad++; $display("FAIL act_next_loc got=%h want=0", loc_obs); end
      end
      if (c == 13) begin
        total++; if (pins_obs !== 5'b01010) begin bad++; $display("FAIL pre_pins got=%b want=01010", pins_obs); end
        total++; if (loc_obs !== loc_vec(3, 2, 0)) begin bad++; $display("FAIL pre_loc got=%h want=%h", loc_obs, loc_vec(3, 2, 0)); end
      end
      if (c == 15) begin
        total++; if (loc_obs !== loc_vec(3, 2, 'h0ffff)) begin bad++; $display("FAIL act_row_max got=%h want=%h", loc_obs, loc_vec(3, 2, 'h0ffff)); end
      end
      total++; if (dp_obs !== 10'd0) begin bad++; $display("FAIL act_no_track c=%0d got=%h want=0", c, dp_obs); end
      step();
    end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL act_err got=%b want=0", err); end
    $display("test_activate_precharge: checks=%0d", total);
  endtask

  task automatic test_read();
    logic [9:0] exp;
    do_reset();
    for (int c = 0; c <= 30; c++) begin
      cmd_i = (c == 9) ? CMD_READ : CMD_NONE;
      cmd_index_i = 2'd1;
      if (c == 10) begin
        total++; if (pins_obs !== 5'b01101) begin bad++; $display("FAIL read_pins got=%b want=01101", pins_obs); end
        total++; if (loc_obs !== loc_vec(2, 1, 'h00155)) begin bad++; $display("FAIL read_loc got=%h want=%h", loc_obs, loc_vec(2, 1, 'h00155)); end
      end
      exp = '0;
      if (c >= 16 && c <= 23) exp = dp_vec(1, 0, c - 16, 1, c == 23, (c == 23) ? 1 : 0);
      total++; if (dp_obs !== exp) begin bad++; $display("FAIL read_path c=%0d got=%h want=%h", c, dp_obs, exp); end
      step();
    end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL read_err got=%b want=0", err); end
    $display("test_read: checks=%0d", total);
  endtask

  task automatic test_write_then_read();
    logic [9:0] exp;
    do_reset();
    for (int c = 0; c <= 36; c++) begin
      cmd_i = CMD_NONE;
      if (c == 9)  begin cmd_i = CMD_WRITE; cmd_index_i = 2'd0; end
      if (c == 19) begin cmd_i = CMD_READ;  cmd_index_i = 2'd3; end
      if (c == 10) begin
        total++; if (pins_obs !== 5'b01100) begin bad++; $display("FAIL write_pins got=%b want=01100", pins_obs); end
        total++; if (loc_obs !== loc_vec(0, 1, 'h00011)) begin bad++; $display("FAIL write_loc got=%h want=%h", loc_obs, loc_vec(0, 1, 'h00011)); end
      end
      if (c == 20) begin
        total++; if (loc_obs !== loc_vec(3, 2, 'h003ff)) begin bad++; $display("FAIL read_col_max got=%h want=%h", loc_obs, loc_vec(3, 2, 'h003ff)); end
      end
      exp = '0;
      if (c >= 14 && c <= 21) exp = dp_vec(0, 1, c - 14, 0, c == 21, 0);
      if (c >= 26 && c <= 33) exp = dp_vec(1, 0, c - 26, 3, c == 33, (c == 33) ? 3 : 0);
      total++; if (dp_obs !== exp) begin bad++; $display("FAIL wr_rd_path c=%0d got=%h want=%h", c, dp_obs, exp); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL wr_rd_err c=%0d got=%b want=0", c, err); end
      step();
    end
    $display("test_write_then_read: checks=%0d", total);
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp;
    do_reset();
    for (int c = 0; c <= 32; c++) begin
      cmd_i = CMD_NONE;
      if (c == 9)  begin cmd_i = CMD_WRITE; cmd_index_i = 2'd0; end
      if (c == 17) begin cmd_i = CMD_WRITE; cmd_index_i = 2'd1; end
      exp = '0;
      if (c >= 14 && c <= 21) exp = dp_vec(0, 1, c - 14, 0, c == 21, 0);
      if (c >= 22 && c <= 29) exp = dp_vec(0, 1, c - 22, 1, c == 29, (c == 29) ? 1 : 0);
      total++; if (dp_obs !== exp) begin bad++; $display("FAIL b2b_path c=%0d got=%h want=%h", c, dp_obs, exp); end
      step();
    end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL b2b_err got=%b want=0", err); end
    $display("test_back_to_back: checks=%0d", total);
  endtask

  task automatic test_collision();
    logic [9:0] exp;
    do_reset();
    for (int c = 0; c <= 36; c++) begin
      cmd_i = CMD_NONE;
      if (c == 9)  begin cmd_i = CMD_READ;  cmd_index_i = 2'd1; end
      if (c == 11) begin cmd_i = CMD_WRITE; cmd_index_i = 2'd2; end
      exp = '0;
      if (c >= 16 && c <= 23) exp = dp_vec(1, 0, c - 16, 1, c == 23, (c == 23) ? 1 : 0);
      if (c >= 24 && c <= 31) exp = dp_vec(0, 1, c - 24, 2, c == 31, (c == 31) ? 2 : 0);
      total++; if (dp_obs !== exp) begin bad++; $display("FAIL collide_path c=%0d got=%h want=%h", c, dp_obs, exp); end
      total++; if (err !== (c >= 16)) begin bad++; $display("FAIL collide_err c=%0d got=%b want=%b", c, err, c >= 16); end
      step();
    end
    $display("test_collision: checks=%0d", total);
  endtask

  task automatic test_overflow();
    logic [9:0] exp;
    do_reset();
    for (int c = 0; c <= 34; c++) begin
      cmd_i = CMD_NONE;
      if (c == 9)  begin cmd_i = CMD_READ;  cmd_index_i = 2'd0; end
      if (c == 10) begin cmd_i = CMD_WRITE; cmd_index_i = 2'd1; end
      if (c == 11) begin cmd_i = CMD_READ;  cmd_index_i = 2'd2; end
      if (c == 11) begin
        total++; if (pins_obs !== 5'b01100) begin bad++; $display("FAIL ovf_write_pins got=%b want=01100", pins_obs); end
      end
      if (c == 12) begin
        total++; if (pins_obs !== 5'b01101) begin bad++; $display("FAIL ovf_third_pins got=%b want=01101", pins_obs); end
        total++; if (loc_obs !== loc_vec(1, 3, 'h002aa)) begin bad++; $display("FAIL ovf_third_loc got=%h want=%h", loc_obs, loc_vec(1, 3, 'h002aa)); end
      end
      exp = '0;
      if (c >= 16 && c <= 23) exp = dp_vec(1, 0, c - 16, 0, c == 23, 0);
      if (c >= 24 && c <= 31) exp = dp_vec(0, 1, c - 24, 1, c == 31, (c == 31) ? 1 : 0);
      total++; if (dp_obs !== exp) begin bad++; $display("FAIL ovf_path c=%0d got=%h want=%h", c, dp_obs, exp); end
      total++; if (err !== (c >= 12)) begin bad++; $display("FAIL ovf_err c=%0d got=%b want=%b", c, err, c >= 12); end
      step();
    end
    $display("test_overflow: checks=%0d", total);
  endtask

  task automatic test_reset_mid_burst();
    logic [9:0] exp;
    do_reset();
    for (int c = 0; c <= 30; c++) begin
      cmd_i = CMD_NONE;
      rst_n = !(c == 19);
      if (c == 9)  begin cmd_i = CMD_READ; cmd_index_i = 2'd3; end
      if (c == 10) begin cmd_i = CMD_READ; cmd_index_i = 2'd0; end
      if (c == 11) begin cmd_i = CMD_READ; cmd_index_i = 2'd1; end
      exp = '0;
      if (c >= 16 && c <= 19) exp = dp_vec(1, 0, c - 16, 3, 0, 0);
      total++; if (dp_obs !== exp) begin bad++; $display("FAIL rst_burst_path c=%0d got=%h want=%h", c, dp_obs, exp); end
      total++; if (err !== (c >= 12 && c <= 19)) begin bad++; $display("FAIL rst_burst_err c=%0d got=%b want=%b", c, err, c >= 12 && c <= 19); end
      step();
    end
    rst_n = 1'b1;
    $display("test_reset_mid_burst: checks=%0d", total);
  endtask

  initial begin
    bg_tbl[0] = 2'd0; ba_tbl[0] = 2'd1; row_tbl[0] = 16'h0abc; col_tbl[0] = 10'h011;
    bg_tbl[1] = 2'd2; ba_tbl[1] = 2'd1; row_tbl[1] = 16'h8001; col_tbl[1] = 10'h155;
    bg_tbl[2] = 2'd1; ba_tbl[2] = 2'd3; row_tbl[2] = 16'h1234; col_tbl[2] = 10'h2aa;
    bg_tbl[3] = 2'd3; ba_tbl[3] = 2'd2; row_tbl[3] = 16'hffff; col_tbl[3] = 10'h3ff;
    test_reset();
    test_activate_precharge();
    test_read();
    test_write_then_read();
    test_back_to_back();
    test_collision();
    test_overflow();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
